// File: rtl/counter_mod_updown.sv
// counter_mod_updown -- synchronous modulo-N up/down counter.
//
// Successor to the 4-bit free-running ripple-carry counter. It counts in
// 0..MODULUS-1 in either direction and has a synchronous clear, a clamped
// parallel load, and 74x163-style dual enables.
//
// Cascading: tie stage k+1 en_t to stage k rco and share en_p across all
// stages. The chain then behaves as one wide modulo counter.
//
// Parameters
//   WIDTH     counter width, 2..16
//   MODULUS   count range 0..MODULUS-1, 2..2**WIDTH
//   RESET_VAL value loaded by rst_n, < MODULUS
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   en_p        parallel count enable (does not affect rco)
//   en_t        trickle/cascade count enable (gates rco)
//   up          1 = count up, 0 = count down
//   clr         synchronous clear to 0 (highest priority)
//   load        synchronous load of load_val (clamped to MODULUS-1)
//   load_val    value to load
//   count       registered count
//   rco         combinational ripple-carry-out
//   wrap        registered pulse, high in the cycle count shows a wrapped value
//
// Optional build macro COUNTER_MOD_STICKY_EN adds two ports:
//   wrap_ack    clears wrap_sticky
//   wrap_sticky latched wrap flag; set wins over ack; clr clears it
module counter_mod_updown #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_p,
  input  logic             en_t,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_MOD_STICKY_EN
  input  logic             wrap_ack,
  output logic             wrap_sticky,
`endif
  output logic [WIDTH-1:0] count,
  output logic             rco,
  output logic             wrap
);

  // Elaboration-time guards on the parameter ranges.
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("counter_mod_updown: WIDTH out of range 2..16");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_mod
    $error("counter_mod_updown: MODULUS out of range 2..2**WIDTH");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_rst
    $error("counter_mod_updown: RESET_VAL must be below MODULUS");
  end

  localparam logic [WIDTH-1:0] TOP  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RSTV = WIDTH'(RESET_VAL);
  // MODULUS may equal 2**WIDTH, so one extra bit is needed to hold it.
  localparam logic [WIDTH:0]   MODX = (WIDTH+1)'(MODULUS);

  typedef struct packed {
    logic [WIDTH-1:0] cnt;
    logic             wrap;
  } nxt_t;

  logic at_top, at_bot, step, load_ok;
  nxt_t nxt;

  assign at_top  = (count == TOP);
  assign at_bot  = (count == '0);
  assign step    = en_p & en_t;
  assign load_ok = ({1'b0, load_val} < MODX);

  // Terminal-count detect depends on the registered count and the live
  // direction/en_t only, so a direction flip at a terminal value shows
  // up on rco without waiting for an edge.
  assign rco = en_t & (up ? at_top : at_bot);

  // Next-state selection: clr > load > count > hold. Wrapping is done by
  // explicit terminal compare so the range is modulo MODULUS rather than
  // modulo 2**WIDTH.
  always_comb begin
    nxt.cnt  = count;
    nxt.wrap = 1'b0;
    if (clr) begin
      nxt.cnt = '0;
    end else if (load) begin
      nxt.cnt = load_ok ? load_val : TOP;
    end else if (step) begin
      if (up) begin
        nxt.cnt  = at_top ? '0 : count + WIDTH'(1);
        nxt.wrap = at_top;
      end else begin
        nxt.cnt  = at_bot ? TOP : count - WIDTH'(1);
        nxt.wrap = at_bot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RSTV;
      wrap  <= 1'b0;
    end else begin
      count <= nxt.cnt;
      wrap  <= nxt.wrap;
    end
  end

`ifdef COUNTER_MOD_STICKY_EN
  // A new wrap on the same edge as an ack keeps the flag set, so no
  // wrap event is ever lost to a late acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          wrap_sticky <= 1'b0;
    else if (clr)        wrap_sticky <= 1'b0;
    else if (nxt.wrap)   wrap_sticky <= 1'b1;
    else if (wrap_ack)   wrap_sticky <= 1'b0;
  end
`endif

endmodule
